// File: rtl/lookup2_hash_if.sv
// lookup2_hash_if: command / key-stream / result handshake bundle for lookup2_hash.
//   start_*  : command (length in bytes, initval), valid/ready
//   key_*    : 32-bit little-endian key words, valid/ready
//   hash_*   : 32-bit result, valid/ready
// master = key source / hash consumer side, slave = hash engine side.
interface lookup2_hash_if #(
  parameter int LEN_W = 16
);
  logic             start_valid;
  logic             start_ready;
  logic [LEN_W-1:0] start_len;
  logic [31:0]      start_initval;
  logic             key_valid;
  logic             key_ready;
  logic [31:0]      key_data;
  logic             hash_valid;
  logic             hash_ready;
  logic [31:0]      hash_data;

  modport master (
    output start_valid, start_len, start_initval, key_valid, key_data, hash_ready,
    input  start_ready, key_ready, hash_valid, hash_data
  );

  modport slave (
    input  start_valid, start_len, start_initval, key_valid, key_data, hash_ready,
    output start_ready, key_ready, hash_valid, hash_data
  );
endinterface

// File: rtl/lookup2_hash.sv
// lookup2_hash: Bob Jenkins lookup2 32-bit hash over a streamed variable-length key.
//   CLK, RST_N : clock, synchronous active-low reset
//   bus        : lookup2_hash_if.slave (start / key / hash handshakes)
// Parameters:
//   LEN_W           : width of the byte-length field
//   STEPS_PER_CYCLE : mix sub-steps evaluated per cycle (1, 3 or 9)
// One hash in flight. Full 12-byte blocks are loaded into k0..k2 and mixed;
// the tail (always present, possibly empty) is masked, folded with the length
// and mixed once more. The result is registered one cycle after the final mix.
module lookup2_hash #(
  parameter int LEN_W           = 16,
  parameter int STEPS_PER_CYCLE = 3
) (
  input logic           CLK,
  input logic           RST_N,
  lookup2_hash_if.slave bus
);

  localparam int          MIX_CYC = 9 / STEPS_PER_CYCLE;
  localparam logic [31:0] GOLDEN  = 32'h9e3779b9;

  generate
    if (!(STEPS_PER_CYCLE == 1 || STEPS_PER_CYCLE == 3 || STEPS_PER_CYCLE == 9)) begin : g_bad_steps
      $error("lookup2_hash: STEPS_PER_CYCLE must be 1, 3 or 9");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_MIX, S_OUT} state_t;

  state_t            state, state_nxt;
  logic [31:0]       a, b, c;
  logic [2:0][31:0]  k;
  logic [LEN_W-1:0]  len_r;
  logic [LEN_W-1:0]  rem;       // bytes not yet folded into a/b/c
  logic [1:0]        widx;      // word slot within the current block
  logic [3:0]        mix_cnt;
  logic              hv_r;
  logic [31:0]       hd_r;

  // current block is the tail once fewer than 12 bytes remain
  logic        is_tail;
  logic [1:0]  wib;             // words in current block
  logic [3:0]  tail_up;
  logic        last_word;
  logic        mix_last;

  assign is_tail   = rem < LEN_W'(12);
  assign tail_up   = rem[3:0] + 4'd3;
  assign wib       = is_tail ? tail_up[3:2] : 2'd3;
  assign last_word = (widx == wib - 2'd1);
  assign mix_last  = (mix_cnt == 4'(MIX_CYC - 1));

  // tail byte mask: byte p survives only if p < rem
  logic [2:0][31:0] tmask;
  always_comb begin
    tmask = '0;
    for (int p = 0; p < 12; p++)
      tmask[p/4][8*(p%4) +: 8] = (LEN_W'(p) < rem) ? 8'hff : 8'h00;
  end

  // block add folded into the first mix cycle, then this cycle's sub-steps
  logic [31:0] ma, mb, mc, k2m;
  logic [3:0]  idx;
  always_comb begin
    ma  = a;
    mb  = b;
    mc  = c;
    k2m = k[2] & tmask[2];
    idx = '0;
    if (mix_cnt == 4'd0) begin
      if (is_tail) begin
        ma = a + (k[0] & tmask[0]);
        mb = b + (k[1] & tmask[1]);
        mc = c + 32'(len_r) + {k2m[23:0], 8'h00};
      end else begin
        ma = a + k[0];
        mb = b + k[1];
        mc = c + k[2];
      end
    end
    for (int s = 0; s < STEPS_PER_CYCLE; s++) begin
      idx = 4'(int'(mix_cnt) * STEPS_PER_CYCLE + s);
      case (idx)
        4'd0: ma = (ma - mb - mc) ^ (mc >> 13);
        4'd1: mb = (mb - mc - ma) ^ (ma << 8);
        4'd2: mc = (mc - ma - mb) ^ (mb >> 13);
        4'd3: ma = (ma - mb - mc) ^ (mc >> 12);
        4'd4: mb = (mb - mc - ma) ^ (ma << 16);
        4'd5: mc = (mc - ma - mb) ^ (mb >> 5);
        4'd6: ma = (ma - mb - mc) ^ (mc >> 3);
        4'd7: mb = (mb - mc - ma) ^ (ma << 10);
        4'd8: mc = (mc - ma - mb) ^ (mb >> 15);
        default: ;
      endcase
    end
  end

  // state register
  always_ff @(posedge CLK) begin
    if (!RST_N) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // next state
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (bus.start_valid)
                state_nxt = (bus.start_len == '0) ? S_MIX : S_LOAD;
      S_LOAD: if (bus.key_valid && last_word) state_nxt = S_MIX;
      S_MIX:  if (mix_last) begin
                if (is_tail)                 state_nxt = S_OUT;
                else if (rem == LEN_W'(12))  state_nxt = S_MIX;  // empty tail follows
                else                         state_nxt = S_LOAD;
              end
      S_OUT:  if (hv_r && bus.hash_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // outputs
  always_comb begin
    bus.start_ready = (state == S_IDLE);
    bus.key_ready   = (state == S_LOAD);
    bus.hash_valid  = hv_r;
    bus.hash_data   = hd_r;
  end

  // datapath
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      a       <= '0;
      b       <= '0;
      c       <= '0;
      k       <= '0;
      len_r   <= '0;
      rem     <= '0;
      widx    <= '0;
      mix_cnt <= '0;
      hv_r    <= 1'b0;
      hd_r    <= '0;
    end else begin
      case (state)
        S_IDLE: if (bus.start_valid) begin
          a       <= GOLDEN;
          b       <= GOLDEN;
          c       <= bus.start_initval;
          len_r   <= bus.start_len;
          rem     <= bus.start_len;
          widx    <= '0;
          mix_cnt <= '0;
        end
        S_LOAD: if (bus.key_valid) begin
          k[widx] <= bus.key_data;
          widx    <= last_word ? 2'd0 : widx + 2'd1;
        end
        S_MIX: begin
          a <= ma;
          b <= mb;
          c <= mc;
          if (mix_last) begin
            mix_cnt <= '0;
            if (!is_tail) rem <= rem - LEN_W'(12);
          end else begin
            mix_cnt <= mix_cnt + 4'd1;
          end
        end
        S_OUT: begin
          if (!hv_r) begin
            hv_r <= 1'b1;
            hd_r <= c;
          end else if (bus.hash_ready) begin
            hv_r <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
